lift_sequencer: RTL and testbench
=================================

Name: lift_sequencer

Overview:
- Single-car (mono-lift) sequencing controller behind the lift controller interface.
- Latches hall up/down and car floor requests and tracks the car's floor from floor_sense.
- Chooses travel direction using a collective-control (SCAN) policy, drives motion and door_open, and times the door dwell.
- Exposes the latched request registers as status lamps.

Parameters:
- N_FLOORS, 12, number of floors; floor 0 is the bottom.
- DOOR_CYCLES, 16, door dwell in clk cycles (>=2).
- TW, $clog2(DOOR_CYCLES), dwell timer width (derived).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- up_rqst  in  N_FLOORS  hall up buttons; level or pulse, sampled each cycle.
- dn_rqst  in  N_FLOORS  hall down buttons.
- flr_rqst  in  N_FLOORS  car floor buttons.
- force_open  in  1  car door-open button.
- floor_sense  in  N_FLOORS  one-hot floor at which the car is aligned; 0 between floors.
- direction  out  1  1 = up, 0 = down.
- motion  out  1  1 = motor drive on.
- door_open  out  1  1 = door commanded open.
- up_rqst_status  out  N_FLOORS  latched up requests.
- dn_rqst_status  out  N_FLOORS  latched down requests.
- flr_rqst_status  out  N_FLOORS  latched car requests.

Behaviour:
- All outputs are registered. Reset values:
  - direction = 1, motion = 0, door_open = 0.
  - All status registers = 0, cur_floor = 0, state = IDLE, timer = 0.
- Reset asserted mid-travel or mid-dwell forces the reset values immediately; there is no recovery of pending requests.
- Request latches:
  - A set bit appears in the status register 1 cycle after the input goes high.
  - A bit stays set until it is cleared by service.
  - If a set and a clear hit the same bit in the same cycle, the clear wins.
- Floor tracking: cur_floor (index) loads the index of floor_sense when floor_sense is exactly one-hot. A zero or multi-hot floor_sense is ignored and cur_floor holds.
- Derived terms, computed from the registered requests:
  - any_above: any request bit at an index > cur_floor.
  - any_below: any request bit at an index < cur_floor.
- States: IDLE, MOVING, DOOR_OPEN.
- IDLE (motion = 0, door_open = 0), checked in this priority order:
  1. force_open, or any latched request at cur_floor: go to DOOR_OPEN.
  2. any_above and (direction = 1 or !any_below): set direction = 1, go to MOVING.
  3. any_below: set direction = 0, go to MOVING.
  4. Otherwise hold; direction is unchanged.
  - Latency: a request at another floor latched at cycle t gives motion = 1 at t+2.
- MOVING (motion = 1, door_open = 0):
  - Stop condition at floor k, i.e. valid one-hot floor_sense = bit k:
    - Direction up: flr_q[k] | up_q[k] | (dn_q[k] & !above(k)) | (k = N_FLOORS-1).
    - Direction down: flr_q[k] | dn_q[k] | (up_q[k] & !below(k)) | (k = 0).
  - If the stop condition holds: next cycle motion = 0 and door_open = 1, go to DOOR_OPEN.
  - Otherwise keep moving.
  - force_open is ignored while moving.
- DOOR_OPEN (door_open = 1, motion = 0):
  - On entry, timer loads DOOR_CYCLES-1 and decrements every cycle.
  - Clear rules, applied every cycle at cur_floor:
    - flr_q is always cleared.
    - Direction up: up_q is cleared; dn_q is cleared if !any_above.
    - Direction down: mirror image of the up rule.
  - force_open, or a new request that is cleared this cycle, reloads the timer.
  - When timer = 0 and no reload: go to IDLE with door_open = 0.
  - Dwell from entry with no reloads is exactly DOOR_CYCLES cycles of door_open = 1.
- Invariant: motion and door_open are never both 1.
- Direction never changes while in MOVING or DOOR_OPEN.
- At the top and bottom floors, a stop is forced even with no request there.

Decomposition:
- Package lift_pkg:
  - state_t enum {IDLE, MOVING, DOOR_OPEN}.
  - DIR_UP = 1'b1, DIR_DN = 1'b0.
  - Helper function for one-hot-to-index.
- Sub-module lift_request_bank: N_FLOORS set/clear latch vector, set input plus clear input, clear wins. Instantiated three times, once each for up, dn and flr.

Test Plan:
- Reset, then flr_rqst[5] pulse at floor 0 -> status[5] = 1 next cycle; motion = 1 two cycles after the latch, direction = 1; floor_sense = bit 5 -> motion = 0, door_open = 1 for 16 cycles; flr_rqst_status[5] = 0.
- Car at floor 3 going up, with up_rqst[6] and dn_rqst[8] -> stops at 6 (clears up[6]), then at 8 (clears dn[8]), then returns to IDLE; direction stays 1 until the next decision.
- Floor sensors pass floors 4 and 5 with no requests while moving -> no stop; multi-hot floor_sense = 0x030 -> ignored, cur_floor unchanged.
- force_open held for 40 cycles during DOOR_OPEN -> door_open stays 1 throughout, then 16 further cycles after release; force_open during MOVING -> no effect.
- Requests at floors 2 and 9 with the car at 5, direction up -> serves 9 first, then reverses and serves 2; car at floor 11 moving up -> forced stop even without a request.
- reset asserted while motion = 1 -> motion = 0, door_open = 0, all status = 0 immediately; after release, requests resume from cur_floor = 0.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared types and helpers for the single-car lift sequencer.
package lift_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MOVING,
      DOOR_OPEN
   } state_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Widest floor vector the index helper accepts.
   localparam int unsigned MAX_FLOORS = 32;
   localparam int unsigned MAX_IDX_W  = 5;

   // Callers gate the result with a one-hot check.
   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_FLOORS-1:0] vec);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         if (vec[i]) idx = idx | MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/lift_request_bank.sv
// Vector of set/clear request latches; a clear beats a set on the same bit.
module lift_request_bank #(
   parameter int N = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] set_i,
   input  logic [N-1:0] clr_i,
   output logic [N-1:0] req_o
);

   logic [N-1:0] req_q, req_d;

   always_comb req_d = (req_q | set_i) & ~clr_i;

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) req_q <= '0;
      else       req_q <= req_d;
   end

   assign req_o = req_q;

endmodule

// File: rtl/lift_sequencer.sv
// Collective-control (SCAN) sequencer for one lift car: request latching,
// floor tracking, direction choice, motor/door commands and door dwell timing.
module lift_sequencer
   import lift_pkg::*;
#(
   parameter int N_FLOORS    = 12,
   parameter int DOOR_CYCLES = 16,
   parameter int TW          = $clog2(DOOR_CYCLES)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_FLOORS-1:0] up_rqst,
   input  logic [N_FLOORS-1:0] dn_rqst,
   input  logic [N_FLOORS-1:0] flr_rqst,
   input  logic                force_open,
   input  logic [N_FLOORS-1:0] floor_sense,
   output logic                direction,
   output logic                motion,
   output logic                door_open,
   output logic [N_FLOORS-1:0] up_rqst_status,
   output logic [N_FLOORS-1:0] dn_rqst_status,
   output logic [N_FLOORS-1:0] flr_rqst_status
);

   localparam int FW = $clog2(N_FLOORS);
   localparam logic [TW-1:0] DWELL_LOAD = TW'(DOOR_CYCLES - 1);

   state_t            state_q, state_d;
   logic              dir_q, dir_d;
   logic              motion_q, motion_d;
   logic              door_q, door_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [FW-1:0]     floor_q, floor_d;

   logic [N_FLOORS-1:0] up_q, dn_q, flr_q;
   logic [N_FLOORS-1:0] up_clr, dn_clr, flr_clr;
   logic [N_FLOORS-1:0] req_all, cur_onehot;
   logic [FW-1:0]       sense_idx;
   logic                sense_valid, any_above, any_below, above_k, below_k;
   logic                req_here, stop_k, reload;

   lift_request_bank #(.N(N_FLOORS)) u_up_bank (
      .clk(clk), .reset(reset), .set_i(up_rqst), .clr_i(up_clr), .req_o(up_q));
   lift_request_bank #(.N(N_FLOORS)) u_dn_bank (
      .clk(clk), .reset(reset), .set_i(dn_rqst), .clr_i(dn_clr), .req_o(dn_q));
   lift_request_bank #(.N(N_FLOORS)) u_flr_bank (
      .clk(clk), .reset(reset), .set_i(flr_rqst), .clr_i(flr_clr), .req_o(flr_q));

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      req_all     = up_q | dn_q | flr_q;
      sense_valid = $onehot(floor_sense);
      sense_idx   = FW'(onehot_to_idx(MAX_FLOORS'(floor_sense)));
      cur_onehot  = '0;
      cur_onehot[floor_q] = 1'b1;
      req_here    = |(req_all & cur_onehot);
      any_above   = 1'b0;
      any_below   = 1'b0;
      above_k     = 1'b0;
      below_k     = 1'b0;
      for (int i = 0; i < N_FLOORS; i++) begin
         if (req_all[i]) begin
            if (i > int'(floor_q))   any_above = 1'b1;
            if (i < int'(floor_q))   any_below = 1'b1;
            if (i > int'(sense_idx)) above_k   = 1'b1;
            if (i < int'(sense_idx)) below_k   = 1'b1;
         end
      end

      // Terminal floors always stop the car, request or not.
      if (dir_q == DIR_UP)
         stop_k = (|(floor_sense & (flr_q | up_q))) | ((|(floor_sense & dn_q)) & !above_k)
                  | floor_sense[N_FLOORS-1];
      else
         stop_k = (|(floor_sense & (flr_q | dn_q))) | ((|(floor_sense & up_q)) & !below_k)
                  | floor_sense[0];

      up_clr  = '0;
      dn_clr  = '0;
      flr_clr = '0;
      if (state_q == DOOR_OPEN) begin
         flr_clr = cur_onehot;
         if (dir_q == DIR_UP) begin
            up_clr = cur_onehot;
            if (!any_above) dn_clr = cur_onehot;
         end else begin
            dn_clr = cur_onehot;
            if (!any_below) up_clr = cur_onehot;
         end
      end
      reload = force_open | (|((up_rqst & up_clr) | (dn_rqst & dn_clr) | (flr_rqst & flr_clr)));
   end

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      motion_d = 1'b0;
      door_d   = 1'b0;
      timer_d  = timer_q;
      floor_d  = sense_valid ? sense_idx : floor_q;
      unique case (state_q)
         IDLE: begin
            if (force_open || req_here) begin
               state_d = DOOR_OPEN;
               door_d  = 1'b1;
               timer_d = DWELL_LOAD;
            end else if (any_above && (dir_q == DIR_UP || !any_below)) begin
               state_d  = MOVING;
               dir_d    = DIR_UP;
               motion_d = 1'b1;
            end else if (any_below) begin
               state_d  = MOVING;
               dir_d    = DIR_DN;
               motion_d = 1'b1;
            end
         end
         MOVING: begin
            if (sense_valid && stop_k) begin
               state_d = DOOR_OPEN;
               door_d  = 1'b1;
               timer_d = DWELL_LOAD;
            end else begin
               motion_d = 1'b1;
            end
         end
         DOOR_OPEN: begin
            if (reload) begin
               door_d  = 1'b1;
               timer_d = DWELL_LOAD;
            end else if (timer_q == '0) begin
               state_d = IDLE;
            end else begin
               door_d  = 1'b1;
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         dir_q    <= DIR_UP;
         motion_q <= 1'b0;
         door_q   <= 1'b0;
         timer_q  <= '0;
         floor_q  <= '0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         motion_q <= motion_d;
         door_q   <= door_d;
         timer_q  <= timer_d;
         floor_q  <= floor_d;
      end
   end

   assign direction       = dir_q;
   assign motion          = motion_q;
   assign door_open       = door_q;
   assign up_rqst_status  = up_q;
   assign dn_rqst_status  = dn_q;
   assign flr_rqst_status = flr_q;

endmodule

// File: tb/tb_lift_sequencer.sv
// Directed bench for lift_sequencer: latching, SCAN stops, dwell timing,
// force_open, terminal-floor stops and asynchronous reset.
module tb_lift_sequencer;

   localparam int N  = 12;
   localparam int DC = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] up_rqst = '0;
   logic [N-1:0] dn_rqst = '0;
   logic [N-1:0] flr_rqst = '0;
   logic         force_open = 1'b0;
   logic [N-1:0] floor_sense = '0;
   logic         direction, motion, door_open;
   logic [N-1:0] up_rqst_status, dn_rqst_status, flr_rqst_status;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;
   int n;

   lift_sequencer #(.N_FLOORS(N), .DOOR_CYCLES(DC)) dut (
      .clk(clk), .reset(reset),
      .up_rqst(up_rqst), .dn_rqst(dn_rqst), .flr_rqst(flr_rqst),
      .force_open(force_open), .floor_sense(floor_sense),
      .direction(direction), .motion(motion), .door_open(door_open),
      .up_rqst_status(up_rqst_status), .dn_rqst_status(dn_rqst_status),
      .flr_rqst_status(flr_rqst_status)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Counts clock edges until the door closes, bounded.
   task automatic wait_close(output int cnt);
      cnt = 0;
      while (door_open === 1'b1 && cnt < 200) begin
         tick();
         cnt++;
      end
   endtask

   function automatic logic [N-1:0] bit_of(input int f);
      logic [N-1:0] one;
      one = 1;
      return one << f;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      floor_sense = bit_of(0);
      tick(); tick();
      check("rst_dir",    32'(direction), 32'd1);
      check("rst_motion", 32'(motion), 32'd0);
      check("rst_door",   32'(door_open), 32'd0);
      check("rst_status", 32'(up_rqst_status | dn_rqst_status | flr_rqst_status), 32'd0);
      reset = 1'b0;

      // Car request to floor 5 from floor 0, passing 4 and a multi-hot glitch.
      flr_rqst = bit_of(5); tick(); flr_rqst = '0;
      check("p1_latch",  32'(flr_rqst_status), 32'h020);
      check("p1_wait",   32'(motion), 32'd0);
      tick();
      check("p1_motion", 32'(motion), 32'd1);
      check("p1_dir",    32'(direction), 32'd1);
      check("p1_door",   32'(door_open), 32'd0);
      floor_sense = '0; tick(); tick();
      floor_sense = bit_of(4); tick();
      check("p1_pass4", 32'(motion), 32'd1);
      floor_sense = 12'h030; tick();
      check("p1_multihot_motion", 32'(motion), 32'd1);
      check("p1_multihot_door",   32'(door_open), 32'd0);
      floor_sense = bit_of(5); tick();
      check("p1_stop_motion", 32'(motion), 32'd0);
      check("p1_stop_door",   32'(door_open), 32'd1);
      wait_close(n);
      check("p1_dwell", 32'(n), 32'd16);
      check("p1_cleared", 32'(flr_rqst_status), 32'd0);
      tick();
      check("p1_idle", 32'(motion | door_open), 32'd0);

      // At floor 5 heading up: hall up at 6, hall down at 8.
      up_rqst = bit_of(6); dn_rqst = bit_of(8); tick();
      up_rqst = '0; dn_rqst = '0;
      check("p2_up_latch", 32'(up_rqst_status), 32'h040);
      check("p2_dn_latch", 32'(dn_rqst_status), 32'h100);
      tick();
      check("p2_motion", 32'(motion), 32'd1);
      floor_sense = '0; tick();
      floor_sense = bit_of(6); tick();
      check("p2_stop6", 32'(door_open), 32'd1);
      tick();
      check("p2_up6_clr", 32'(up_rqst_status), 32'd0);
      check("p2_dn8_kept", 32'(dn_rqst_status), 32'h100);
      wait_close(n);
      check("p2_dwell6", 32'(n), 32'd15);
      tick();
      check("p2_resume", 32'(motion), 32'd1);
      check("p2_resume_dir", 32'(direction), 32'd1);
      floor_sense = '0; tick();
      floor_sense = bit_of(7); tick();
      check("p2_pass7", 32'(motion), 32'd1);
      floor_sense = bit_of(8); tick();
      check("p2_stop8", 32'(door_open), 32'd1);
      wait_close(n);
      check("p2_dwell8", 32'(n), 32'd16);
      check("p2_dn8_clr", 32'(dn_rqst_status), 32'd0);
      check("p2_dir_kept", 32'(direction), 32'd1);
      tick();
      check("p2_idle", 32'(motion | door_open), 32'd0);

      // force_open held 40 cycles at floor 8.
      force_open = 1'b1;
      n = 0;
      repeat (40) begin
         tick();
         if (door_open === 1'b1) n++;
      end
      check("p4_held_open", 32'(n), 32'd40);
      force_open = 1'b0;
      wait_close(n);
      check("p4_after_release", 32'(n), 32'd16);

      // From 8 going up: car calls at 9 and 2; force_open while moving.
      flr_rqst = bit_of(9) | bit_of(2); tick(); flr_rqst = '0;
      check("p5_latch", 32'(flr_rqst_status), 32'h204);
      tick();
      check("p5_motion_up", 32'(motion), 32'd1);
      force_open = 1'b1; floor_sense = '0; tick();
      check("p5_force_moving", 32'(motion), 32'd1);
      check("p5_force_door", 32'(door_open), 32'd0);
      force_open = 1'b0;
      floor_sense = bit_of(9); tick();
      check("p5_stop9", 32'(door_open), 32'd1);
      wait_close(n);
      check("p5_dwell9", 32'(n), 32'd16);
      check("p5_left2", 32'(flr_rqst_status), 32'h004);
      check("p5_dir_still_up", 32'(direction), 32'd1);
      tick();
      check("p5_reverse_motion", 32'(motion), 32'd1);
      check("p5_reverse_dir", 32'(direction), 32'd0);
      floor_sense = '0; tick();
      floor_sense = bit_of(4); tick();
      check("p5_pass4_down", 32'(motion), 32'd1);
      floor_sense = bit_of(2); tick();
      check("p5_stop2", 32'(door_open), 32'd1);
      wait_close(n);
      check("p5_all_clear", 32'(up_rqst_status | dn_rqst_status | flr_rqst_status), 32'd0);

      // Call at 10, sensor reports 11: top floor forces a stop.
      flr_rqst = bit_of(10); tick(); flr_rqst = '0;
      tick();
      check("top_motion", 32'(motion), 32'd1);
      check("top_dir", 32'(direction), 32'd1);
      floor_sense = '0; tick();
      floor_sense = bit_of(11); tick();
      check("top_forced_door", 32'(door_open), 32'd1);
      check("top_forced_motion", 32'(motion), 32'd0);
      wait_close(n);
      check("top_pending10", 32'(flr_rqst_status), 32'h400);
      tick();
      check("top_down_motion", 32'(motion), 32'd1);
      check("top_down_dir", 32'(direction), 32'd0);
      floor_sense = '0; up_rqst = bit_of(3); tick(); up_rqst = '0;
      check("mid_up3_latch", 32'(up_rqst_status), 32'h008);

      // Asynchronous reset mid-travel, no clock edge needed.
      reset = 1'b1; #1;
      check("arst_motion", 32'(motion), 32'd0);
      check("arst_door", 32'(door_open), 32'd0);
      check("arst_dir", 32'(direction), 32'd1);
      check("arst_status", 32'(up_rqst_status | dn_rqst_status | flr_rqst_status), 32'd0);
      tick();
      reset = 1'b0;

      // After reset the car believes it is at floor 0.
      flr_rqst = bit_of(0); tick(); flr_rqst = '0;
      check("post_rst_latch", 32'(flr_rqst_status), 32'h001);
      tick();
      check("post_rst_door", 32'(door_open), 32'd1);
      check("post_rst_motion", 32'(motion), 32'd0);
      repeat (3) tick();
      flr_rqst = bit_of(0); tick(); flr_rqst = '0;
      check("clear_wins", 32'(flr_rqst_status), 32'd0);
      wait_close(n);
      check("new_req_reload", 32'(n), 32'd16);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
